// File: rtl/bgr_pkg.sv
// Shared types and helpers for the bandgap startup/trim sequencer.
// Contents: FSM state enum, mid-scale trim helper, watchdog filter length.
// Imported by bgr_sar_ch and bgr_trim_sequencer.
package bgr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STARTUP,
        ST_WAIT_OK,
        ST_SETTLE,
        ST_DECIDE,
        ST_DONE,
        ST_FAULT
    } bgr_state_e;

    // Consecutive low vbg_ok cycles in DONE before a restart is forced.
    localparam int WDT_FILTER = 4;

    // Mid-scale ladder tap: only the MSB of the trim code set.
    function automatic int unsigned trim_mid(input int unsigned trim_w);
        return 32'd1 << (trim_w - 1);
    endfunction

endpackage

// File: rtl/bgr_trim_sequencer_if.sv
// Handshake/bus bundle between the power-management side and the trim sequencer.
// Ports: start/abort/vbg_ok/cmp_hi towards the sequencer; porst/trim_code/busy/done/fault back.
// master = controller/environment side, slave = sequencer side.
interface bgr_trim_sequencer_if #(
    parameter int N_CH   = 1,
    parameter int TRIM_W = 5
);
    logic                     start;
    logic                     abort;
    logic [N_CH-1:0]          vbg_ok;
    logic [N_CH-1:0]          cmp_hi;
    logic [N_CH-1:0]          porst;
    logic [N_CH*TRIM_W-1:0]   trim_code;
    logic                     busy;
    logic                     done;
    logic                     fault;

    modport master (
        output start, abort, vbg_ok, cmp_hi,
        input  porst, trim_code, busy, done, fault
    );

    modport slave (
        input  start, abort, vbg_ok, cmp_hi,
        output porst, trim_code, busy, done, fault
    );
endinterface

// File: rtl/bgr_sar_ch.sv
// One channel's SAR trim-code register.
// Ports: clk, rst_n; strobes clr/load_mid/set_bit/decide; bit_idx = bit under test; cmp_hi; code out.
// Priority load_mid > clr > decide/set_bit; code resets to mid-scale.
module bgr_sar_ch
    import bgr_pkg::*;
#(
    parameter int TRIM_W = 5,
    parameter int BIT_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load_mid,
    input  logic              set_bit,
    input  logic              decide,
    input  logic [BIT_W-1:0]  bit_idx,
    input  logic              cmp_hi,
    output logic [TRIM_W-1:0] code
);
    localparam logic [TRIM_W-1:0] MID = TRIM_W'(trim_mid(TRIM_W));

    logic [TRIM_W-1:0] cur_mask;
    logic [TRIM_W-1:0] low_mask;
    logic [TRIM_W-1:0] code_nxt;

    // In a decide cycle set_bit refers to the next lower bit, so a single
    // bit_idx serves both the bit being resolved and the one being tried.
    always_comb begin
        cur_mask = TRIM_W'(1) << bit_idx;
        low_mask = cur_mask >> 1;
        code_nxt = code;
        if (decide && cmp_hi) begin
            code_nxt = code_nxt & ~cur_mask;
        end
        if (set_bit) begin
            code_nxt = code_nxt | (decide ? low_mask : cur_mask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code <= MID;
        end else if (load_mid) begin
            code <= MID;
        end else if (clr) begin
            code <= '0;
        end else begin
            code <= code_nxt;
        end
    end
endmodule

// File: rtl/bgr_trim_sequencer.sv
// Startup-and-trim controller for N_CH bandgap cores: porst pulse, vbg_ok check, per-channel SAR trim.
// Ports: clk, rst_n, bus (slave): start/abort/vbg_ok/cmp_hi in; porst/trim_code/busy/done/fault out.
// Optional BGR_RESTART_WDT_EN: in DONE, 4 consecutive cycles of any vbg_ok low restart the sequence.
module bgr_trim_sequencer
    import bgr_pkg::*;
#(
    parameter int N_CH        = 1,
    parameter int TRIM_W      = 5,
    parameter int STARTUP_CYC = 16,
    parameter int SETTLE_CYC  = 64,
    parameter int MAX_RETRY   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bgr_trim_sequencer_if.slave   bus
);
    localparam int MAX_CYC = (STARTUP_CYC > SETTLE_CYC) ? STARTUP_CYC : SETTLE_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int RET_W   = $clog2(MAX_RETRY + 1);
    localparam int BIT_W   = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
    localparam logic [BIT_W-1:0] TOP_BIT = BIT_W'(TRIM_W - 1);

    bgr_state_e         state;
    logic [CNT_W-1:0]   cnt;
    logic [RET_W-1:0]   retry;
    logic [BIT_W-1:0]   bit_q;
    logic               porst_q;
    logic               busy_q;
    logic               done_q;
    logic               fault_q;

    logic all_ok;
    logic go;
    logic ok_now;
    logic wait_to;
    logic fault_now;
    logic sar_clr;
    logic sar_mid;
    logic sar_set;
    logic sar_dec;
    logic wdt_trip;

`ifdef BGR_RESTART_WDT_EN
    logic [$clog2(WDT_FILTER)-1:0] wdt_cnt;
`endif

    always_comb begin
        all_ok    = &bus.vbg_ok;
        go        = bus.start && (state == ST_IDLE || state == ST_DONE || state == ST_FAULT);
        ok_now    = (state == ST_WAIT_OK) && all_ok;
        wait_to   = (state == ST_WAIT_OK) && !all_ok && (cnt == CNT_W'(SETTLE_CYC - 1));
        fault_now = wait_to && (retry == RET_W'(MAX_RETRY - 1));
`ifdef BGR_RESTART_WDT_EN
        wdt_trip  = (state == ST_DONE) && !all_ok && (wdt_cnt == $bits(wdt_cnt)'(WDT_FILTER - 1));
`else
        wdt_trip  = 1'b0;
`endif
        // Code-register strobes fire on the same edge as the matching FSM transition.
        sar_clr = !bus.abort && go;
        sar_mid = bus.abort || fault_now;
        sar_set = !bus.abort && (ok_now || ((state == ST_DECIDE) && (bit_q != '0)));
        sar_dec = !bus.abort && (state == ST_DECIDE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            retry   <= '0;
            bit_q   <= TOP_BIT;
            porst_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else if (bus.abort) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            retry   <= '0;
            bit_q   <= TOP_BIT;
            porst_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_FAULT: begin
                    // Watchdog restart keeps the codes; only start clears them (via sar_clr).
                    if (go || wdt_trip) begin
                        state   <= ST_STARTUP;
                        cnt     <= '0;
                        retry   <= '0;
                        bit_q   <= TOP_BIT;
                        porst_q <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        fault_q <= 1'b0;
                    end
                end
                ST_STARTUP: begin
                    if (cnt == CNT_W'(STARTUP_CYC - 1)) begin
                        state   <= ST_WAIT_OK;
                        cnt     <= '0;
                        porst_q <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_OK: begin
                    if (all_ok) begin
                        state <= ST_SETTLE;
                        cnt   <= '0;
                    end else if (wait_to) begin
                        cnt   <= '0;
                        retry <= retry + RET_W'(1);
                        if (fault_now) begin
                            state   <= ST_FAULT;
                            busy_q  <= 1'b0;
                            fault_q <= 1'b1;
                        end else begin
                            state   <= ST_STARTUP;
                            porst_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                        state <= ST_DECIDE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DECIDE: begin
                    if (bit_q != '0) begin
                        bit_q <= bit_q - BIT_W'(1);
                        state <= ST_SETTLE;
                    end else begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef BGR_RESTART_WDT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_cnt <= '0;
        end else if (bus.abort || state != ST_DONE || all_ok || wdt_trip) begin
            wdt_cnt <= '0;
        end else begin
            wdt_cnt <= wdt_cnt + 1'b1;
        end
    end
`endif

    logic [N_CH*TRIM_W-1:0] code_all;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        bgr_sar_ch #(
            .TRIM_W (TRIM_W),
            .BIT_W  (BIT_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (sar_clr),
            .load_mid (sar_mid),
            .set_bit  (sar_set),
            .decide   (sar_dec),
            .bit_idx  (bit_q),
            .cmp_hi   (bus.cmp_hi[c]),
            .code     (code_all[c*TRIM_W +: TRIM_W])
        );
    end

    assign bus.porst     = {N_CH{porst_q}};
    assign bus.trim_code = code_all;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.fault     = fault_q;
endmodule

// File: tb/tb_bgr_trim_sequencer.sv
// Bench for bgr_trim_sequencer with N_CH=2, TRIM_W=5, STARTUP_CYC=16, SETTLE_CYC=64, MAX_RETRY=3.
// Random comparator targets checked against a plain-arithmetic SAR reference and latency formula.
// Honours BGR_RESTART_WDT_EN for the DONE watchdog scenario.
module tb_bgr_trim_sequencer;
    localparam int N_CH        = 2;
    localparam int TRIM_W      = 5;
    localparam int STARTUP_CYC = 16;
    localparam int SETTLE_CYC  = 64;
    localparam int MAX_RETRY   = 3;
    localparam int LAT         = STARTUP_CYC + 1 + TRIM_W * (SETTLE_CYC + 1) + 1;
    localparam int FAULT_LAT   = MAX_RETRY * (STARTUP_CYC + SETTLE_CYC) + 1;
    localparam logic [9:0] MID2 = {5'd16, 5'd16};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bgr_trim_sequencer_if #(.N_CH(N_CH), .TRIM_W(TRIM_W)) bus();

    bgr_trim_sequencer #(
        .N_CH        (N_CH),
        .TRIM_W      (TRIM_W),
        .STARTUP_CYC (STARTUP_CYC),
        .SETTLE_CYC  (SETTLE_CYC),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int t0     = 0;
    int lat;

    logic [4:0] tgt   [N_CH];
    logic       stuck [N_CH];

    always @(posedge clk) cyc <= cyc + 1;

    // Comparator model: stuck channels always report "above target".
    always_comb begin
        bus.cmp_hi = '0;
        for (int c = 0; c < N_CH; c++) begin
            bus.cmp_hi[c] = stuck[c] | (bus.trim_code[c*TRIM_W +: TRIM_W] > tgt[c]);
        end
    end

    // porst pulse monitor.
    int  pulses = 0;
    int  plen[$];
    int  run = 0;
    bit  porst_bad = 0;
    always @(negedge clk) begin
        if (bus.porst != '0 && bus.porst != '1) porst_bad = 1;
        if (bus.porst[0]) begin
            if (run == 0) pulses++;
            run++;
        end else if (run != 0) begin
            plen.push_back(run);
            run = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference SAR: try each bit MSB first, keep it unless the comparator says "too high".
    function automatic logic [4:0] sar_ref(input logic [4:0] t, input logic st);
        int code = 0;
        for (int b = TRIM_W - 1; b >= 0; b--) begin
            code += (1 << b);
            if (st || code > int'(t)) code -= (1 << b);
        end
        return 5'(code);
    endfunction

    function automatic logic [9:0] exp_codes();
        return {sar_ref(tgt[1], stuck[1]), sar_ref(tgt[0], stuck[0])};
    endfunction

    task automatic clr_mon();
        pulses = 0;
        plen.delete();
        porst_bad = 0;
    endtask

    task automatic start_seq();
        @(negedge clk);
        bus.start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_for(input bit want_fault, input int limit, output int l);
        l = -1;
        for (int i = 0; i < limit; i++) begin
            if (want_fault ? bus.fault : bus.done) begin
                l = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        chk(want_fault ? "fault_seen" : "done_seen", (l >= 0) ? 1 : 0, 1);
    endtask

    task automatic wait_until(input int rel);
        for (int i = 0; i < 2000 && (cyc - t0) < rel; i++) @(negedge clk);
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.vbg_ok = 2'b11;
        tgt[0] = 5'd13; tgt[1] = 5'd22;
        stuck[0] = 1'b0; stuck[1] = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_porst", bus.porst, 0);
        chk("rst_code", bus.trim_code, MID2);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_fault", bus.fault, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal run, targets 13/22.
        clr_mon();
        start_seq();
        chk("s1_busy", bus.busy, 1);
        chk("s1_porst_on", bus.porst, 2'b11);
        wait_for(0, LAT + 50, lat);
        chk("s1_lat", lat, LAT);
        chk("s1_code", bus.trim_code, {5'd22, 5'd13});
        chk("s1_pulses", pulses, 1);
        chk("s1_plen", (plen.size() > 0) ? plen[0] : 0, STARTUP_CYC);
        chk("s1_porst_eq", porst_bad, 0);
        chk("s1_busy_end", bus.busy, 0);
        chk("s1_fault", bus.fault, 0);

        // Random targets, including stuck comparators, restarted from DONE.
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < N_CH; c++) begin
                tgt[c]   = 5'($urandom_range(0, 31));
                stuck[c] = ($urandom_range(0, 3) == 0);
            end
            if (i == 0) stuck[1] = 1'b1;
            if (i == 1) begin tgt[0] = 5'd31; stuck[0] = 1'b0; end
            clr_mon();
            start_seq();
            wait_for(0, LAT + 50, lat);
            chk("rnd_lat", lat, LAT);
            chk("rnd_code", bus.trim_code, exp_codes());
            chk("rnd_pulses", pulses, 1);
        end

        // start inside SETTLE is ignored.
        tgt[0] = 5'd13; tgt[1] = 5'd22; stuck[0] = 1'b0; stuck[1] = 1'b0;
        start_seq();
        wait_until(60);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_for(0, LAT + 50, lat);
        chk("s5_lat", lat, LAT);
        chk("s5_code", bus.trim_code, {5'd22, 5'd13});

        // DONE watchdog: 3 low cycles never trip; 4 trip only with the feature built in.
        clr_mon();
        bus.vbg_ok = 2'b01;
        repeat (3) @(negedge clk);
        bus.vbg_ok = 2'b11;
        repeat (5) @(negedge clk);
        chk("wdt3_done", bus.done, 1);
        chk("wdt3_porst", pulses, 0);
        bus.vbg_ok = 2'b01;
        repeat (3) @(negedge clk);
        chk("wdt_pre_done", bus.done, 1);
        @(negedge clk);
`ifdef BGR_RESTART_WDT_EN
        chk("wdt_done_drop", bus.done, 0);
        chk("wdt_porst", bus.porst, 2'b11);
        chk("wdt_busy", bus.busy, 1);
        bus.vbg_ok = 2'b11;
        t0 = cyc;
        wait_for(0, LAT + 50, lat);
`else
        chk("nowdt_done", bus.done, 1);
        chk("nowdt_porst", bus.porst, 0);
        bus.vbg_ok = 2'b11;
`endif

        // Startup failure: one core never comes up.
        bus.vbg_ok = 2'b01;
        clr_mon();
        start_seq();
        wait_for(1, FAULT_LAT + 50, lat);
        chk("s2_lat", lat, FAULT_LAT);
        chk("s2_pulses", pulses, MAX_RETRY);
        for (int i = 0; i < plen.size(); i++) chk("s2_plen", plen[i], STARTUP_CYC);
        chk("s2_code", bus.trim_code, MID2);
        chk("s2_busy", bus.busy, 0);
        chk("s2_done", bus.done, 0);

        // Late vbg_ok during the second WAIT_OK, started from FAULT.
        bus.vbg_ok = 2'b00;
        tgt[0] = 5'($urandom_range(0, 31)); tgt[1] = 5'($urandom_range(0, 31));
        clr_mon();
        start_seq();
        for (int i = 0; i < 500 && !(pulses == 2 && bus.porst == '0); i++) @(negedge clk);
        repeat ($urandom_range(0, 40)) @(negedge clk);
        bus.vbg_ok = 2'b11;
        wait_for(0, 2 * LAT, lat);
        chk("s3_pulses", pulses, 2);
        chk("s3_fault", bus.fault, 0);
        chk("s3_code", bus.trim_code, exp_codes());

        // abort during SETTLE of bit 2, then a full re-run.
        start_seq();
        wait_until(STARTUP_CYC + 2 + 2 * (SETTLE_CYC + 1) + $urandom_range(1, 60));
        chk("s4_busy_pre", bus.busy, 1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("s4_porst", bus.porst, 0);
        chk("s4_code", bus.trim_code, MID2);
        chk("s4_busy", bus.busy, 0);
        repeat (5) @(negedge clk);
        chk("s4_idle", bus.busy, 0);
        clr_mon();
        start_seq();
        wait_for(0, LAT + 50, lat);
        chk("s4_rerun_lat", lat, LAT);
        chk("s4_rerun_code", bus.trim_code, exp_codes());

        // abort in the final DECIDE cycle beats the move to DONE.
        start_seq();
        wait_until(LAT - 1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("ab_last_done", bus.done, 0);
        chk("ab_last_code", bus.trim_code, MID2);

        // abort during STARTUP drops porst.
        start_seq();
        repeat (5) @(negedge clk);
        chk("ab_st_porst_on", bus.porst, 2'b11);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("ab_st_porst", bus.porst, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
